// File: rtl/wb_write_sequencer_if.sv
// Writeback sequencer bus: two result producers in, register file write port and bypass query out.
// The sequencer itself connects through the slave modport; producers and the register file use master.
interface wb_write_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              memValid;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              memReady;

    logic              aluValid;
    logic [ADDR_W-1:0] aluAddr;
    logic [DATA_W-1:0] aluData;
    logic              aluReady;

    logic              regWrite;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    logic [ADDR_W-1:0] lookupAddr;
    logic              bypassHit;
    logic [DATA_W-1:0] bypassData;

    modport master (
        output memValid, memAddr, memData,
        output aluValid, aluAddr, aluData,
        output lookupAddr,
        input  memReady, aluReady,
        input  regWrite, writeAddr, writeData,
        input  count, empty, full,
        input  bypassHit, bypassData
    );

    modport slave (
        input  memValid, memAddr, memData,
        input  aluValid, aluAddr, aluData,
        input  lookupAddr,
        output memReady, aluReady,
        output regWrite, writeAddr, writeData,
        output count, empty, full,
        output bypassHit, bypassData
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// Serialises ALU and load results onto one register file write port through a small FIFO.
// Define WB_BYPASS_EN to add the combinational lookup of pending writes (BypassHit/BypassData).
module wb_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    wb_write_sequencer_if.slave seqIf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              memReady;
    logic              aluReady;
    logic              memPush;
    logic              aluPush;
    logic              pop;
    logic [PTR_W-1:0]  aluSlot;

    // Ready looks only at the registered count; the ALU needs two free slots
    // so that a simultaneous load and ALU retire always fit.
    assign memReady = (count_q <  CNT_W'(DEPTH));
    assign aluReady = (count_q <= CNT_W'(DEPTH - 2));

    assign memPush  = seqIf.memValid && memReady && (seqIf.memAddr != '0);
    assign aluPush  = seqIf.aluValid && aluReady && (seqIf.aluAddr != '0);
    assign pop      = (count_q != '0);
    assign aluSlot  = wrPtr_q + PTR_W'(memPush);

    always_comb begin
        rdPtr_d = rdPtr_q + PTR_W'(pop);
        wrPtr_d = wrPtr_q + PTR_W'(memPush) + PTR_W'(aluPush);
        count_d = count_q + CNT_W'(memPush) + CNT_W'(aluPush) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots covered by count_q are ever observed.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (memPush) begin
                addrMem_q[wrPtr_q] <= seqIf.memAddr;
                dataMem_q[wrPtr_q] <= seqIf.memData;
            end
            if (aluPush) begin
                addrMem_q[aluSlot] <= seqIf.aluAddr;
                dataMem_q[aluSlot] <= seqIf.aluData;
            end
        end
    end

    assign seqIf.memReady  = memReady;
    assign seqIf.aluReady  = aluReady;
    assign seqIf.regWrite  = pop;
    assign seqIf.writeAddr = pop ? addrMem_q[rdPtr_q] : '0;
    assign seqIf.writeData = pop ? dataMem_q[rdPtr_q] : '0;
    assign seqIf.count     = count_q;
    assign seqIf.empty     = (count_q == '0);
    assign seqIf.full      = (count_q == CNT_W'(DEPTH));

`ifdef WB_BYPASS_EN
    logic              bypassHit;
    logic [DATA_W-1:0] bypassData;
    logic [PTR_W-1:0]  bypassSlot;

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        bypassHit  = 1'b0;
        bypassData = '0;
        bypassSlot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bypassSlot = rdPtr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (seqIf.lookupAddr != '0) &&
                (addrMem_q[bypassSlot] == seqIf.lookupAddr)) begin
                bypassHit  = 1'b1;
                bypassData = dataMem_q[bypassSlot];
            end
        end
    end

    assign seqIf.bypassHit  = bypassHit;
    assign seqIf.bypassData = bypassData;
`else
    logic unusedLookup;

    assign unusedLookup     = ^seqIf.lookupAddr;
    assign seqIf.bypassHit  = 1'b0;
    assign seqIf.bypassData = '0;
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Scoreboard bench for wb_write_sequencer: stimulus pushes expected writes, a monitor pops them
// as the register file write port fires. Bypass checks follow WB_BYPASS_EN.
module tb_wb_write_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   modelCount = 0;
    bit   monitorOn = 1'b0;
    exp_t expQ[$];
    logic [DATA_W-1:0] shadowRf [32];

    wb_write_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) seqIf ();

    wb_write_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .seqIf (seqIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called just after a rising edge: checks the current state against the model,
    // drives one cycle of producer inputs and records whatever the model says gets accepted.
    task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                 input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 output logic memAcc, output logic aluAcc);
        logic expMemReady;
        logic expAluReady;
        int   pushes;
        exp_t e;
        expMemReady = (modelCount < DEPTH);
        expAluReady = (modelCount <= DEPTH - 2);
        checkOutput("MemReady", 32'(seqIf.memReady), 32'(expMemReady));
        checkOutput("AluReady", 32'(seqIf.aluReady), 32'(expAluReady));
        checkOutput("Count",    32'(seqIf.count),    32'(modelCount));
        checkOutput("Empty",    32'(seqIf.empty),    32'(modelCount == 0));
        checkOutput("Full",     32'(seqIf.full),     32'(modelCount == DEPTH));
        seqIf.memValid = mv;
        seqIf.memAddr  = ma;
        seqIf.memData  = md;
        seqIf.aluValid = av;
        seqIf.aluAddr  = aa;
        seqIf.aluData  = ad;
        memAcc = mv && expMemReady;
        aluAcc = av && expAluReady;
        pushes = 0;
        if (memAcc && ma != '0) begin
            e.addr = ma;
            e.data = md;
            expQ.push_back(e);
            pushes++;
        end
        if (aluAcc && aa != '0) begin
            e.addr = aa;
            e.data = ad;
            expQ.push_back(e);
            pushes++;
        end
        modelCount = modelCount + pushes - ((modelCount > 0) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        logic mAcc, aAcc;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, mAcc, aAcc);
    endtask

    // Monitor: every write presented on the port must be the oldest outstanding expectation.
    initial begin
        exp_t e;
        wait (monitorOn);
        forever begin
            @(negedge clk);
            if (seqIf.regWrite === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL UnexpectedWrite actual addr=%0d data=%h required no write at %0t",
                             seqIf.writeAddr, seqIf.writeData, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("WriteAddr", 32'(seqIf.writeAddr), 32'(e.addr));
                    checkOutput("WriteData", seqIf.writeData, e.data);
                    shadowRf[seqIf.writeAddr] = seqIf.writeData;
                end
            end else begin
                checkOutput("RegWriteIdle",  32'(seqIf.regWrite),  32'd0);
                checkOutput("IdleWriteAddr", 32'(seqIf.writeAddr), 32'd0);
                checkOutput("IdleWriteData", seqIf.writeData,      32'd0);
            end
        end
    end

    initial begin
        logic mAcc, aAcc;
        int   mi;
        int   ai;
        for (int i = 0; i < 32; i++) shadowRf[i] = '0;
        seqIf.memValid   = 1'b0;
        seqIf.memAddr    = '0;
        seqIf.memData    = '0;
        seqIf.aluValid   = 1'b0;
        seqIf.aluAddr    = '0;
        seqIf.aluData    = '0;
        seqIf.lookupAddr = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("ResetCount",    32'(seqIf.count),     32'd0);
        checkOutput("ResetRegWrite", 32'(seqIf.regWrite),  32'd0);
        checkOutput("ResetEmpty",    32'(seqIf.empty),     32'd1);
        checkOutput("ResetBypassHit",32'(seqIf.bypassHit), 32'd0);
        monitorOn = 1'b1;

        // Reset mid-stream with three entries queued.
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, mAcc, aAcc);
        applyStimulus(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, mAcc, aAcc);
        checkOutput("PreResetCount", 32'(seqIf.count), 32'd3);
        rst = 1'b1;
        seqIf.memValid = 1'b0;
        seqIf.aluValid = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        modelCount = 0;
        checkOutput("MidResetCount",     32'(seqIf.count),     32'd0);
        checkOutput("MidResetRegWrite",  32'(seqIf.regWrite),  32'd0);
        checkOutput("MidResetWriteAddr", 32'(seqIf.writeAddr), 32'd0);
        checkOutput("MidResetMemReady",  32'(seqIf.memReady),  32'd1);
        checkOutput("MidResetAluReady",  32'(seqIf.aluReady),  32'd1);
        rst = 1'b0;
        idleCycles(2);

        // Single ALU write.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd8, 32'h0000_00FF, mAcc, aAcc);
        idleCycles(3);
        checkOutput("Reg8", shadowRf[8], 32'h0000_00FF);

        // Dual retire to the same register: ALU value lands last.
        applyStimulus(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222, mAcc, aAcc);
        idleCycles(4);
        checkOutput("Reg5Final", shadowRf[5], 32'h2222_2222);

        // Writes to $zero complete the handshake but never reach the port.
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF, mAcc, aAcc);
        checkOutput("ZeroAccepted", 32'(aAcc), 32'd1);
        idleCycles(3);

        // Pending-write bypass.
        applyStimulus(1'b1, 5'd9, 32'h0000_000A, 1'b1, 5'd9, 32'h0000_000B, mAcc, aAcc);
        seqIf.memValid   = 1'b0;
        seqIf.aluValid   = 1'b0;
        seqIf.lookupAddr = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        checkOutput("BypassHit9",  32'(seqIf.bypassHit), 32'd1);
        checkOutput("BypassData9", seqIf.bypassData,     32'h0000_000B);
`else
        checkOutput("BypassHitOff",  32'(seqIf.bypassHit), 32'd0);
        checkOutput("BypassDataOff", seqIf.bypassData,     32'd0);
`endif
        seqIf.lookupAddr = 5'd0;
        #1;
        checkOutput("BypassHitZero", 32'(seqIf.bypassHit), 32'd0);
        idleCycles(4);

        // Backpressure: both producers stay valid, data advances only on acceptance.
        mi = 0;
        ai = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 5'(1 + mi), 32'h1000 + 32'(mi),
                          1'b1, 5'(11 + ai), 32'h2000 + 32'(ai), mAcc, aAcc);
            if (mAcc) mi++;
            if (aAcc) ai++;
        end
        checkOutput("SaturatedCount", 32'(seqIf.count), 32'd3);
        idleCycles(DEPTH + 3);
        checkOutput("DrainQueue", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
